sp_rom_arbiter: RTL

- Round-robin arbiter and read sequencer that shares one single-port synchronous ROM (WIDTH x DEPTH, 1-cycle registered read) between NUM_REQ requesters.
- Accepts one read per cycle, drives the ROM address register, and tracks in-flight reads in a 2-stage tag pipeline.
- Returns registered data to the originating requester with fixed latency.
- Sits between the ROM instance and its consumers; the ROM itself stays outside this block.

---
 rtl/sp_rom_arbiter_if.sv | 35 +++
 rtl/sp_rom_arbiter.sv | 134 +++++++++++++
 2 files changed

// File: rtl/sp_rom_arbiter_if.sv
// rtl/sp_rom_arbiter_if.sv - requester-side bus of the shared ROM read arbiter
//
// Bundles the NUM_REQ request channels and the shared response channel.
//   req_valid  per-requester read request
//   req_addr   requester i address at [i*DEPTH_LOG +: DEPTH_LOG]
//   req_ready  one-hot grant
//   rsp_valid  one-hot response strobe
//   rsp_id     index of the responding requester
//   rsp_data   read data (0 on error)
//   rsp_err    address was out of range
// master: requester side, slave: arbiter side.
interface sp_rom_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int DEPTH_LOG = 4,
    parameter int ID_W      = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*DEPTH_LOG-1:0] req_addr;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ-1:0]           rsp_valid;
    logic [ID_W-1:0]              rsp_id;
    logic [WIDTH-1:0]             rsp_data;
    logic                         rsp_err;

    modport master (
        output req_valid, req_addr,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/sp_rom_arbiter.sv
// rtl/sp_rom_arbiter.sv - round-robin read sequencer sharing one single-port ROM
//
// Grants one requester per cycle (round-robin from ptr), drives the ROM
// address register and carries {valid, id, err} through a 2-stage tag
// pipeline so the registered response lands 3 cycles after the handshake.
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   bus       requester bus (slave modport)
//   rom_addr  registered address to ROM addr_rd
//   rom_data  ROM data_out (valid 2 cycles after the handshake)
module sp_rom_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int DEPTH_LOG = $clog2(DEPTH),
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    sp_rom_arbiter_if.slave      bus,
    output logic [DEPTH_LOG-1:0] rom_addr,
    input  logic [WIDTH-1:0]     rom_data
);

    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic [DEPTH_LOG-1:0] rom_addr_q, rom_addr_d;
    logic                 s1_vld_q, s1_vld_d;
    logic [ID_W-1:0]      s1_id_q, s1_id_d;
    logic                 s1_err_q, s1_err_d;
    logic                 s2_vld_q, s2_vld_d;
    logic [ID_W-1:0]      s2_id_q, s2_id_d;
    logic                 s2_err_q, s2_err_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]     rsp_data_q, rsp_data_d;
    logic                 rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0]   grant;
    logic                 found;
    logic [ID_W-1:0]      grant_idx;
    logic [DEPTH_LOG-1:0] grant_addr;
    logic                 grant_err;

    // Round-robin search starting at ptr; reset suppresses every grant.
    always_comb begin
        int idx;
        grant     = '0;
        found     = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
            end
        end
        if (rst) begin
            grant = '0;
            found = 1'b0;
        end
    end

    assign grant_addr = bus.req_addr[int'(grant_idx)*DEPTH_LOG +: DEPTH_LOG];
    // Out-of-range reads still go to the ROM; only the response is masked.
    assign grant_err  = (int'(grant_addr) >= DEPTH);

    always_comb begin
        ptr_d       = ptr_q;
        rom_addr_d  = rom_addr_q;
        s1_vld_d    = found;
        s1_id_d     = s1_id_q;
        s1_err_d    = s1_err_q;
        if (found) begin
            ptr_d      = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
            rom_addr_d = grant_addr;
            s1_id_d    = grant_idx;
            s1_err_d   = grant_err;
        end

        s2_vld_d    = s1_vld_q;
        s2_id_d     = s1_id_q;
        s2_err_d    = s1_err_q;

        // id/data only move on a real response so they hold while idle.
        rsp_valid_d = s2_vld_q ? (NUM_REQ'(1) << s2_id_q) : '0;
        rsp_err_d   = s2_vld_q & s2_err_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        if (s2_vld_q) begin
            rsp_id_d   = s2_id_q;
            rsp_data_d = s2_err_q ? '0 : rom_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            rom_addr_q  <= '0;
            s1_vld_q    <= 1'b0;
            s1_id_q     <= '0;
            s1_err_q    <= 1'b0;
            s2_vld_q    <= 1'b0;
            s2_id_q     <= '0;
            s2_err_q    <= 1'b0;
            rsp_valid_q <= '0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            rom_addr_q  <= rom_addr_d;
            s1_vld_q    <= s1_vld_d;
            s1_id_q     <= s1_id_d;
            s1_err_q    <= s1_err_d;
            s2_vld_q    <= s2_vld_d;
            s2_id_q     <= s2_id_d;
            s2_err_q    <= s2_err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign rom_addr      = rom_addr_q;

endmodule
